// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with registered sync/blank decodes and a delayed sync path.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int DELAY     = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       hs_d,
  output logic       vs_d,
  output logic       blank_d,
  output logic       line_start,
  output logic       frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] x_q, x_d, y_q, y_d, nx, ny;
  logic       h_sync_q, h_sync_d, v_sync_q, v_sync_d, vis_q, vis_d;
  logic       ls_q, ls_d, fs_q, fs_d, x_wrap, y_wrap;

  // Decodes are taken from the next position so they line up with the registered counters.
  always_comb begin
    x_wrap   = x_q == H_LAST;
    y_wrap   = y_q == V_LAST;
    nx       = x_wrap ? '0 : x_q + 10'd1;
    ny       = x_wrap ? (y_wrap ? '0 : y_q + 10'd1) : y_q;
    x_d      = pix_en ? nx : x_q;
    y_d      = pix_en ? ny : y_q;
    h_sync_d = pix_en ? !(nx >= HS_BEG && nx < HS_END) : h_sync_q;
    v_sync_d = pix_en ? !(ny >= VS_BEG && ny < VS_END) : v_sync_q;
    vis_d    = pix_en ? (nx < H_VIS && ny < V_VIS) : vis_q;
    ls_d     = pix_en && x_wrap;
    fs_d     = pix_en && x_wrap && y_wrap;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q      <= '0;
      y_q      <= '0;
      h_sync_q <= 1'b1;
      v_sync_q <= 1'b1;
      vis_q    <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      h_sync_q <= h_sync_d;
      v_sync_q <= v_sync_d;
      vis_q    <= vis_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign hs          = h_sync_q;
  assign vs          = v_sync_q;
  assign blank       = vis_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

  // Delay line runs every cycle, independent of pix_en; stage word is {hs, vs, blank}.
  if (DELAY == 0) begin : g_nodly
    assign {hs_d, vs_d, blank_d} = {h_sync_q, v_sync_q, vis_q};
  end else begin : g_dly
    logic [2:0] dly_q [DELAY];
    logic [2:0] dly_d [DELAY];
    always_comb begin
      dly_d[0] = {h_sync_q, v_sync_q, vis_q};
      for (int i = 1; i < DELAY; i++) dly_d[i] = dly_q[i-1];
    end
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) for (int i = 0; i < DELAY; i++) dly_q[i] <= 3'b110;
      else dly_q <= dly_d;
    end
    assign {hs_d, vs_d, blank_d} = dly_q[DELAY-1];
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench on a reduced raster (30x17) with DELAY=2 and DELAY=0 instances.
module tb_vga_timing_gen;
  localparam int HV = 16, HF = 4, HSW = 6, HB = 4;
  localparam int VV = 10, VF = 2, VSW = 2, VB = 3;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [9:0] x, y;
    logic hs, vs, blank, ls, fs, hs_d, vs_d, blank_d;
  } obs_t;
  localparam obs_t RST = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, blank: 1'b0,
                           ls: 1'b0, fs: 1'b0, hs_d: 1'b1, vs_d: 1'b1, blank_d: 1'b0};

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  logic pix_en = 1'b0;
  logic [9:0] DrawX, DrawY, dx0, dy0;
  logic blank, hs, vs, hs_d, vs_d, blank_d, line_start, frame_start;
  logic bl0, hs0, vs0, hsd0, vsd0, bld0, ls0, fs0;
  obs_t o1, o0;
  assign o1 = {DrawX, DrawY, hs, vs, blank, line_start, frame_start, hs_d, vs_d, blank_d};
  assign o0 = {dx0, dy0, hs0, vs0, bl0, ls0, fs0, hsd0, vsd0, bld0};

  vga_timing_gen #(.H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                   .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .DELAY(2)) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .pix_en(pix_en), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .hs(hs), .vs(vs), .hs_d(hs_d), .vs_d(vs_d), .blank_d(blank_d),
    .line_start(line_start), .frame_start(frame_start));

  vga_timing_gen #(.H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                   .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .DELAY(0)) dut0 (
    .vga_clk(vga_clk), .reset_n(reset_n), .pix_en(pix_en), .DrawX(dx0), .DrawY(dy0),
    .blank(bl0), .hs(hs0), .vs(vs0), .hs_d(hsd0), .vs_d(vsd0), .blank_d(bld0),
    .line_start(ls0), .frame_start(fs0));

  always #5 vga_clk = ~vga_clk;

  int checks = 0, errors = 0;
  int p = 0;
  bit adv = 0;
  logic [2:0] hist [$];
  obs_t sb [$];

  function automatic void model_reset();
    p = 0;
    adv = 0;
    hist = {3'b110, 3'b110};
  endfunction

  // Position is tracked as a linear pixel index; x/y and all decodes are derived from it.
  task automatic drive(input bit en);
    obs_t e;
    int x, y;
    @(negedge vga_clk);
    pix_en = en;
    if (en) begin
      p = (p + 1) % FRAME;
      adv = 1;
    end
    x = p % HT;
    y = p / HT;
    e.x = 10'(x);
    e.y = 10'(y);
    e.hs = !(x >= HV + HF && x < HV + HF + HSW);
    e.vs = !(y >= VV + VF && y < VV + VF + VSW);
    e.blank = adv && x < HV && y < VV;
    e.ls = en && x == 0;
    e.fs = en && p == 0;
    {e.hs_d, e.vs_d, e.blank_d} = hist.pop_front();
    hist.push_back({e.hs, e.vs, e.blank});
    sb.push_back(e);
    @(posedge vga_clk);
    #2;
  endtask

  always @(posedge vga_clk) begin
    obs_t e, e0;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      e0 = e;
      {e0.hs_d, e0.vs_d, e0.blank_d} = {e.hs, e.vs, e.blank};
      checks++;
      if (o1 !== e) begin
        errors++;
        $display("FAIL sb_delay2 t=%0t got=%h want=%h", $time, o1, e);
      end
      checks++;
      if (o0 !== e0) begin
        errors++;
        $display("FAIL sb_delay0 t=%0t got=%h want=%h", $time, o0, e0);
      end
    end
  end

  task automatic seek(input int target);
    while (p != target) drive(1);
  endtask

  task automatic test_reset();
    model_reset();
    reset_n = 0;
    pix_en = 0;
    repeat (3) @(posedge vga_clk);
    #2;
    checks++;
    if (o1 !== RST || o0 !== RST) begin
      errors++;
      $display("FAIL reset_state got=%h/%h want=%h", o1, o0, RST);
    end
    @(negedge vga_clk);
    reset_n = 1;
    repeat (3) drive(0);
    checks++;
    if (blank !== 1'b0 || DrawX !== 10'd0) begin
      errors++;
      $display("FAIL blank_before_first_pix blank=%b x=%0d want 0,0", blank, DrawX);
    end
    drive(1);
    checks++;
    if (blank !== 1'b1 || DrawX !== 10'd1) begin
      errors++;
      $display("FAIL first_pix blank=%b x=%0d want 1,1", blank, DrawX);
    end
  endtask

  task automatic test_hold();
    obs_t s;
    bit bad = 0;
    seek(5 * HT + HV + HF - 1);
    s = o1;
    repeat (50) begin
      drive(0);
      if ({o1.x, o1.y, o1.hs, o1.vs, o1.blank} !== {s.x, s.y, s.hs, s.vs, s.blank} ||
          hs !== 1'b1 || line_start !== 1'b0 || frame_start !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold_static got=%h want=%h with hs=1", o1, s);
    end
    drive(1);
    checks++;
    if (DrawX !== 10'(HV + HF) || hs !== 1'b0) begin
      errors++;
      $display("FAIL hold_release x=%0d hs=%b want %0d,0", DrawX, hs, HV + HF);
    end
  endtask

  task automatic test_delay();
    logic [2:0] got;
    seek(3 * HT + HV - 1);
    drive(1);
    got[0] = blank_d;
    checks++;
    if (blank !== 1'b0) begin
      errors++;
      $display("FAIL blank_fall blank=%b want 0", blank);
    end
    drive(1);
    got[1] = blank_d;
    drive(1);
    got[2] = blank_d;
    checks++;
    if (got !== 3'b011) begin
      errors++;
      $display("FAIL blank_d_lag got=%b want=011", got);
    end
    seek(3 * HT + HV + HF - 1);
    drive(1);
    got[0] = hs_d;
    drive(1);
    got[1] = hs_d;
    drive(1);
    got[2] = hs_d;
    checks++;
    if (got !== 3'b011 || hs !== 1'b0) begin
      errors++;
      $display("FAIL hs_d_lag got=%b hs=%b want=011,0", got, hs);
    end
  endtask

  task automatic test_wrap();
    seek(FRAME - 1);
    checks++;
    if (DrawX !== 10'(HT - 1) || DrawY !== 10'(VT - 1)) begin
      errors++;
      $display("FAIL wrap_pre x=%0d y=%0d want %0d,%0d", DrawX, DrawY, HT - 1, VT - 1);
    end
    drive(1);
    checks++;
    if ({DrawX, DrawY, line_start, frame_start} !== {20'd0, 2'b11}) begin
      errors++;
      $display("FAIL wrap x=%0d y=%0d ls=%b fs=%b want 0,0,1,1", DrawX, DrawY, line_start, frame_start);
    end
    drive(1);
    checks++;
    if ({line_start, frame_start} !== 2'b00) begin
      errors++;
      $display("FAIL wrap_pulse_end ls=%b fs=%b want 0,0", line_start, frame_start);
    end
  endtask

  task automatic test_half_rate();
    logic [9:0] px;
    bit bad = 0, prev_ls = 0;
    int wraps = 0;
    for (int i = 0; i < 4 * HT; i++) begin
      px = DrawX;
      drive(i % 2 == 0);
      if (i % 2 == 1 && DrawX !== px) bad = 1;
      if (line_start && prev_ls) bad = 1;
      if (line_start && DrawX == 10'd0) wraps++;
      prev_ls = line_start;
    end
    checks++;
    if (bad || wraps != 2) begin
      errors++;
      $display("FAIL half_rate bad=%0d wraps=%0d want 0,2", bad, wraps);
    end
  endtask

  task automatic test_full_frames();
    int nh = 0, nv = 0, nb = 0, nl = 0, nf = 0;
    repeat (2 * FRAME) begin
      drive(1);
      nh += int'(!hs);
      nv += int'(!vs);
      nb += int'(blank);
      nl += int'(line_start);
      nf += int'(frame_start);
    end
    checks++;
    if (nh != 2 * HSW * VT || nv != 2 * VSW * HT || nb != 2 * HV * VV) begin
      errors++;
      $display("FAIL frame_counts hs=%0d vs=%0d blank=%0d want %0d %0d %0d",
               nh, nv, nb, 2 * HSW * VT, 2 * VSW * HT, 2 * HV * VV);
    end
    checks++;
    if (nl != 2 * VT || nf != 2) begin
      errors++;
      $display("FAIL pulse_counts ls=%0d fs=%0d want %0d 2", nl, nf, 2 * VT);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    seek(8 * HT + 10);
    #1;
    pix_en = 0;
    reset_n = 0;
    #1;
    checks++;
    if (o1 !== RST || o0 !== RST) begin
      errors++;
      $display("FAIL async_reset got=%h/%h want=%h", o1, o0, RST);
    end
    model_reset();
    @(negedge vga_clk);
    reset_n = 1;
    while (n < FRAME + 10) begin
      drive(1);
      n++;
      if (frame_start) break;
    end
    checks++;
    if (n != FRAME || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL first_frame_start after %0d pix cycles fs=%b want %0d", n, frame_start, FRAME);
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_delay();
    test_wrap();
    test_half_rate();
    test_full_frames();
    test_async_reset();
    @(posedge vga_clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16; H_SYNC, default 96; H_BP, default 48 (horizontal porch/sync widths in pixels).
REQ-003 The block SHALL have parameter V_VISIBLE, default 480; V_FP, default 10; V_SYNC, default 2; V_BP, default 33 (vertical widths in lines).
REQ-004 The block SHALL have parameter DELAY, default 2, range 0-4: vga_clk cycles of alignment delay for the delayed sync outputs.
REQ-005 vga_clk  input  1  single clock; all registers on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 pix_en  input  1  pixel-advance enable; counters move only on cycles where it is high.
REQ-008 DrawX  output  10  current horizontal position, 0 to H_TOTAL-1.
REQ-009 DrawY  output  10  current vertical position, 0 to V_TOTAL-1.
REQ-010 blank  output  1  high = visible pixel (DrawX<H_VISIBLE and DrawY<V_VISIBLE); low = blanking.
REQ-011 hs, vs  output  1 each  active-low sync, aligned with DrawX/DrawY.
REQ-012 hs_d, vs_d, blank_d  output  1 each  hs/vs/blank delayed DELAY vga_clk cycles, for alignment with the registered RGB path.
REQ-013 line_start, frame_start  output  1 each  single-cycle pulses.

Function
REQ-014 H_TOTAL SHALL equal H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL SHALL equal V_VISIBLE+V_FP+V_SYNC+V_BP (525).
REQ-015 On a pix_en cycle DrawX SHALL increment by 1; at DrawX=H_TOTAL-1 it SHALL wrap to 0 and DrawY SHALL increment.
REQ-016 DrawY SHALL wrap from V_TOTAL-1 to 0 on the same cycle as the DrawX wrap at position (H_TOTAL-1, V_TOTAL-1).
REQ-017 With pix_en low, DrawX, DrawY, hs, vs and blank SHALL hold; no pulse SHALL be generated.
REQ-018 hs, vs and blank SHALL be registered decodes of the next counter value, valid in the same cycle as the matching DrawX/DrawY.
REQ-019 hs SHALL be 0 iff H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC (656-751); else 1.
REQ-020 vs SHALL be 0 iff V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC (490-491); else 1.
REQ-021 line_start SHALL be 1 for exactly the one vga_clk cycle after a pix_en cycle that wraps DrawX to 0; 0 otherwise.
REQ-022 frame_start SHALL be 1 for exactly the one vga_clk cycle after a pix_en cycle that moves the counters to (0,0); it coincides with line_start.
REQ-023 The delay line SHALL advance every vga_clk cycle regardless of pix_en; DELAY=0 SHALL make hs_d/vs_d/blank_d combinationally equal to hs/vs/blank.
REQ-024 Counter arithmetic SHALL be unsigned 10-bit; no value >= H_TOTAL or >= V_TOTAL SHALL ever appear on DrawX/DrawY.

Reset
REQ-025 While reset_n=0: DrawX=0, DrawY=0, hs=1, vs=1, blank=0, line_start=0, frame_start=0, every delay stage hs/vs=1, blank=0.
REQ-026 blank SHALL stay 0 after reset release until the first pix_en cycle; pixel (0,0) of the first frame is therefore blanked, and from then on REQ-010 applies.
REQ-027 Reset asserted mid-frame SHALL return all state to REQ-025 values immediately, without waiting for a clock edge.
REQ-028 After reset release, the first frame_start SHALL occur after exactly H_TOTAL*V_TOTAL (420000) pix_en cycles.

Verification
REQ-029 pix_en tied 1, run 2 frames -> hs low exactly 96 cycles per 800, vs low exactly 2 lines (1600 cycles) per 525 lines, blank high 640x480 = 307200 cycles per frame.
REQ-030 Count from (799,524) with pix_en=1 -> next cycle DrawX=0, DrawY=0, line_start=1, frame_start=1; following cycle both 0.
REQ-031 pix_en toggling 1,0 (half rate) -> DrawX advances every 2nd cycle, still wraps 799->0, pulses stay 1 cycle wide.
REQ-032 DELAY=2, DrawX 639->640 transition -> blank falls in that cycle, blank_d falls exactly 2 vga_clk cycles later; hs_d/vs_d likewise.
REQ-033 Assert reset_n=0 at (300,200) between clock edges -> outputs reach REQ-025 values before the next edge; release -> first frame_start after 420000 pix_en cycles.
REQ-034 Hold pix_en=0 for 50 cycles at (655,100) -> all outputs static, hs=1; first pix_en cycle after -> DrawX=656, hs=0.
